// File: rtl/video_timing_gen.sv
// Raster timing generator with built-in test patterns.
// Every output is registered one clock after the counter state it describes.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  pattern_sel,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
    localparam logic [11:0] H_SS    = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SE    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
    localparam logic [11:0] V_SS    = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SE    = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
    localparam logic [11:0] BAR_W12 = 12'(BAR_W);

    logic [11:0] h_cnt, v_cnt, h_next, v_next;
    logic [2:0]  pat_q, pat_eff;
    logic [11:0] bar_div;
    logic [2:0]  bar_idx;
    logic        at_origin, active, hs_on, vs_on;
    logic [23:0] bar_rgb, rgb_c;

    assign at_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_on     = (h_cnt >= H_SS) && (h_cnt < H_SE);
    assign vs_on     = (v_cnt >= V_SS) && (v_cnt < V_SE);
    // New selection applies to the pixel at the origin itself.
    assign pat_eff   = (at_origin && en) ? pattern_sel : pat_q;

    always_comb begin
        h_next = h_cnt + 12'd1;
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = 12'd0;
            v_next = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end
    end

    assign bar_div = h_cnt / BAR_W12;
    assign bar_idx = (bar_div > 12'd7) ? 3'd7 : bar_div[2:0];

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        rgb_c = 24'h000000;
        case (pat_eff)
            3'd0:    rgb_c = 24'h000000;
            3'd1:    rgb_c = bar_rgb;
            3'd2:    rgb_c = {h_cnt[7:0], v_cnt[7:0], 8'h80};
            3'd3:    rgb_c = (h_cnt[5] ^ v_cnt[5]) ? 24'hFFFFFF : 24'h000000;
            default: rgb_c = 24'hFFFFFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= 12'd0;
            v_cnt       <= 12'd0;
            pat_q       <= 3'd0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            red         <= 8'h00;
            green       <= 8'h00;
            blue        <= 8'h00;
            x           <= 12'd0;
            y           <= 12'd0;
        end else if (en) begin
            h_cnt              <= h_next;
            v_cnt              <= v_next;
            pat_q              <= pat_eff;
            de                 <= active;
            frame_start        <= at_origin;
            hsync              <= hs_on ? HS_POL : ~HS_POL;
            vsync              <= vs_on ? VS_POL : ~VS_POL;
            {red, green, blue} <= active ? rgb_c : 24'h000000;
            x                  <= h_cnt;
            y                  <= v_cnt;
        end else begin
            // Frozen: position and syncs hold, no valid pixel is presented.
            de                 <= 1'b0;
            frame_start        <= 1'b0;
            {red, green, blue} <= 24'h000000;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a default 720p instance plus a small, negative-sync instance
// for frame-level behaviour within a short run.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        d_rst, d_en, d_de, d_hs, d_vs, d_fs;
    logic [2:0]  d_sel;
    logic [7:0]  d_r, d_g, d_b;
    logic [11:0] d_x, d_y;

    logic        s_rst, s_en, s_de, s_hs, s_vs, s_fs;
    logic [2:0]  s_sel;
    logic [7:0]  s_r, s_g, s_b;
    logic [11:0] s_x, s_y;

    video_timing_gen u_def (
        .clk(clk), .rst(d_rst), .en(d_en), .pattern_sel(d_sel),
        .de(d_de), .hsync(d_hs), .vsync(d_vs),
        .red(d_r), .green(d_g), .blue(d_b),
        .x(d_x), .y(d_y), .frame_start(d_fs)
    );

    video_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_BP(8),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_small (
        .clk(clk), .rst(s_rst), .en(s_en), .pattern_sel(s_sel),
        .de(s_de), .hsync(s_hs), .vsync(s_vs),
        .red(s_r), .green(s_g), .blue(s_b),
        .x(s_x), .y(s_y), .frame_start(s_fs)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic d_goto(input int tx, input int ty);
        int n = 0;
        while (!(d_x == 12'(tx) && d_y == 12'(ty)) && n < 20000) begin
            step();
            n++;
        end
        chk("d_goto", 32'(d_x == 12'(tx) && d_y == 12'(ty)), 32'd1);
    endtask

    task automatic s_goto(input int tx, input int ty);
        int n = 0;
        while (!(s_x == 12'(tx) && s_y == 12'(ty)) && n < 8000) begin
            step();
            n++;
        end
        chk("s_goto", 32'(s_x == 12'(tx) && s_y == 12'(ty)), 32'd1);
    endtask

    initial begin
        int de_cnt, hs_cnt;
        d_rst = 1'b1; d_en = 1'b1; d_sel = 3'd1;
        s_rst = 1'b1; s_en = 1'b1; s_sel = 3'd3;

        // ---------------- default 1280x720 instance ----------------
        step();
        chk("d_rst_de", 32'(d_de), 32'd0);
        chk("d_rst_fs", 32'(d_fs), 32'd0);
        chk("d_rst_hs", 32'(d_hs), 32'd0);
        chk("d_rst_vs", 32'(d_vs), 32'd0);
        chk("d_rst_xy", {d_x, 4'd0, d_y}, 32'd0);
        chk("d_rst_rgb", {d_r, d_g, d_b}, 32'h000000);
        d_rst = 1'b0;
        step();
        chk("d_first_fs", 32'(d_fs), 32'd1);
        chk("d_first_de", 32'(d_de), 32'd1);
        chk("d_bar0_x0", {d_r, d_g, d_b}, 32'hFFFFFF);
        step();
        chk("d_fs_once", 32'(d_fs), 32'd0);
        d_goto(159, 0);
        chk("d_bar0_x159", {d_r, d_g, d_b}, 32'hFFFFFF);
        step();
        chk("d_bar1_x160", {d_r, d_g, d_b}, 32'hFFFF00);
        d_goto(1120, 0);
        chk("d_bar7_x1120", {d_r, d_g, d_b}, 32'h000000);
        chk("d_de_x1120", 32'(d_de), 32'd1);
        d_goto(1279, 0);
        chk("d_de_x1279", 32'(d_de), 32'd1);
        step();
        chk("d_de_x1280", 32'(d_de), 32'd0);
        chk("d_blank_rgb", {d_r, d_g, d_b}, 32'h000000);
        d_goto(1389, 0);
        chk("d_hs_1389", 32'(d_hs), 32'd0);
        step();
        chk("d_hs_1390", 32'(d_hs), 32'd1);
        d_goto(1429, 0);
        chk("d_hs_1429", 32'(d_hs), 32'd1);
        step();
        chk("d_hs_1430", 32'(d_hs), 32'd0);
        d_goto(0, 1);
        de_cnt = 0;
        hs_cnt = 0;
        for (int i = 0; i < 1650; i++) begin
            if (d_de) de_cnt++;
            if (d_hs) hs_cnt++;
            step();
        end
        chk("d_line_de", 32'(de_cnt), 32'd1280);
        chk("d_line_hs", 32'(hs_cnt), 32'd40);
        chk("d_line_len", {d_x, 4'd0, d_y}, {12'd0, 4'd0, 12'd2});
        // Pattern 2 after a reset restart
        d_sel = 3'd2;
        d_rst = 1'b1;
        step();
        chk("d_rst2_xy", {d_x, 4'd0, d_y}, 32'd0);
        d_rst = 1'b0;
        step();
        chk("d_p2_origin", {d_r, d_g, d_b}, 32'h000080);
        chk("d_p2_fs", 32'(d_fs), 32'd1);
        d_goto(300, 5);
        chk("d_p2_300_5", {d_r, d_g, d_b}, 32'h2C0580);
        chk("d_vs_y5", 32'(d_vs), 32'd0);

        // ---------------- small instance: H_TOTAL 80, V_TOTAL 48 ----------------
        d_en = 1'b0;
        step();
        chk("s_rst_de", 32'(s_de), 32'd0);
        chk("s_rst_hs", 32'(s_hs), 32'd1);
        chk("s_rst_vs", 32'(s_vs), 32'd1);
        s_rst = 1'b0;
        step();
        chk("s_first_fs", 32'(s_fs), 32'd1);
        chk("s_first_xy", {s_x, 4'd0, s_y}, 32'd0);
        chk("s_chk_0_0", {s_r, s_g, s_b}, 32'h000000);
        s_goto(32, 0);
        chk("s_chk_32_0", {s_r, s_g, s_b}, 32'hFFFFFF);
        s_goto(32, 32);
        chk("s_chk_32_32", {s_r, s_g, s_b}, 32'h000000);
        s_goto(79, 41);
        chk("s_vs_41", 32'(s_vs), 32'd1);
        step();
        chk("s_vs_42", 32'(s_vs), 32'd0);
        s_goto(79, 43);
        chk("s_vs_43", 32'(s_vs), 32'd0);
        step();
        chk("s_vs_44", 32'(s_vs), 32'd1);

        // Freeze with counters sitting at the origin
        s_goto(79, 47);
        s_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s_frz0_fs", 32'(s_fs), 32'd0);
        end
        chk("s_frz0_xy", {s_x, 4'd0, s_y}, {12'd79, 4'd0, 12'd47});
        s_en = 1'b1;
        step();
        chk("s_resume_fs", 32'(s_fs), 32'd1);
        step();
        chk("s_resume_fs2", 32'(s_fs), 32'd0);

        // Mid-frame select change 3 -> 1 waits for the next frame
        s_sel = 3'd1;
        s_goto(8, 1);
        chk("s_sw1_hold", {s_r, s_g, s_b}, 32'h000000);
        s_goto(79, 47);
        step();
        chk("s_sw1_fs", 32'(s_fs), 32'd1);
        chk("s_sw1_bar0", {s_r, s_g, s_b}, 32'hFFFFFF);
        s_goto(8, 0);
        chk("s_sw1_bar1", {s_r, s_g, s_b}, 32'hFFFF00);
        // 1 -> 3 at line 10
        s_goto(0, 10);
        s_sel = 3'd3;
        s_goto(32, 20);
        chk("s_sw3_hold", {s_r, s_g, s_b}, 32'hFF00FF);
        s_goto(79, 47);
        step();
        chk("s_sw3_origin", {s_r, s_g, s_b}, 32'h000000);
        s_goto(32, 0);
        chk("s_sw3_32_0", {s_r, s_g, s_b}, 32'hFFFFFF);

        // Enable drop for 10 clocks mid-line
        s_goto(20, 3);
        s_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("s_frz_de", 32'(s_de), 32'd0);
            chk("s_frz_x", 32'(s_x), 32'd20);
        end
        chk("s_frz_rgb", {s_r, s_g, s_b}, 32'h000000);
        s_en = 1'b1;
        step();
        chk("s_unfrz_x", 32'(s_x), 32'd21);
        chk("s_unfrz_de", 32'(s_de), 32'd1);
        for (int i = 0; i < 59; i++) step();
        chk("s_unfrz_wrap", {s_x, 4'd0, s_y}, {12'd0, 4'd0, 12'd4});

        // Mid-frame reset
        s_goto(40, 5);
        s_rst = 1'b1;
        step();
        chk("s_mrst_de", 32'(s_de), 32'd0);
        chk("s_mrst_hs", 32'(s_hs), 32'd1);
        chk("s_mrst_vs", 32'(s_vs), 32'd1);
        chk("s_mrst_xy", {s_x, 4'd0, s_y}, 32'd0);
        chk("s_mrst_rgb_fs", {s_r, s_g, s_b, 7'd0, s_fs}, 32'd0);
        s_rst = 1'b0;
        step();
        chk("s_mrst_de1", 32'(s_de), 32'd1);
        chk("s_mrst_fs1", 32'(s_fs), 32'd1);
        chk("s_mrst_xy1", {s_x, 4'd0, s_y}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
